// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_MEM_LAT = 2;
  // Counter width: holds MEM_LAT-1 for MEM_LAT in 1..15.
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter timing the memory access latency; zero flag marks
// the last ACCESS cycle.
module arb_lat_cnt #(
  parameter int unsigned       W        = 4,
  parameter logic [W-1:0]      LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] cnt;

  // Load on a new grant, otherwise count down while the access is in flight.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= LOAD_VAL;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and data memory (DM) requesters of the multi-cycle core.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie break instead of
// fixed DM-over-IF priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t state;
  owner_t owner;
  owner_t pick;
  logic   cur_we;
  logic   req_any;
  logic   arb_slot;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  assign req_any  = if_req | dm_req;
  assign arb_slot = (state == ST_IDLE) || (state == ST_RESP);
  assign cnt_load = arb_slot && req_any;
  assign cnt_dec  = (state == ST_ACCESS) && !cnt_zero;
  assign busy     = (state != ST_IDLE);

  // Winner selection for the current arbitration edge.
  always_comb begin
    pick = dm_req ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) pick = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
`endif
  end

  arb_lat_cnt #(
    .W        (CNT_W),
    .LOAD_VAL (CNT_W'(MEM_LAT - 1))
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // Arbitration FSM with registered strobes and completion pulses.
  // Read data is valid during RESP, so capture and the rvalid/done pulse
  // are issued on the RESP edge, together with the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      cur_we     <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_IF;
`endif
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_done   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (state == ST_RESP) begin
            if (owner == OWN_IF) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              dm_done <= 1'b1;
              if (!cur_we) dm_rdata <= mem_rdata;
            end
          end
          if (req_any) begin
            owner  <= pick;
            cur_we <= (pick == OWN_DM) && dm_we;
            mem_we <= (pick == OWN_DM) && dm_we;
            mem_en <= 1'b1;
            if_gnt <= (pick == OWN_IF);
            dm_gnt <= (pick == OWN_DM);
            if (pick == OWN_DM) begin
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_addr  <= if_addr;
            end
`ifdef MEM_ARB_RR_EN
            last_owner <= pick;
`endif
            state <= ST_ACCESS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
